// File: rtl/decode_stage_if.sv
// Signal bundle around the LC-3b decode stage: fetch handshake, register file
// read port, forwarding/write-back buses, and the ID/EX pipeline entry.
interface decode_stage_if;
    logic        in_valid;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready;

    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] sr1_data;
    logic [15:0] sr2_data;

    logic        ex_fwd_we;
    logic [2:0]  ex_fwd_dr;
    logic [15:0] ex_fwd_data;
    logic        mem_fwd_we;
    logic [2:0]  mem_fwd_dr;
    logic [15:0] mem_fwd_data;
    logic        wb_we;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;

    logic        flush;
    logic        ex_ready;

    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_op1;
    logic [15:0] id_op2;
    logic [15:0] id_imm;
    logic [2:0]  id_dr;
    logic        id_we;
    logic        id_is_load;

    // The decode stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc,
        input  sr1_data, sr2_data,
        input  ex_fwd_we, ex_fwd_dr, ex_fwd_data,
        input  mem_fwd_we, mem_fwd_dr, mem_fwd_data,
        input  wb_we, wb_dr, wb_data,
        input  flush, ex_ready,
        output in_ready, sr1, sr2,
        output id_valid, id_instr, id_pc, id_op1, id_op2, id_imm,
        output id_dr, id_we, id_is_load
    );

    // The surrounding pipeline: fetch, register file, EX/MEM/WB.
    modport master (
        output in_valid, in_instr, in_pc,
        output sr1_data, sr2_data,
        output ex_fwd_we, ex_fwd_dr, ex_fwd_data,
        output mem_fwd_we, mem_fwd_dr, mem_fwd_data,
        output wb_we, wb_dr, wb_data,
        output flush, ex_ready,
        input  in_ready, sr1, sr2,
        input  id_valid, id_instr, id_pc, id_op1, id_op2, id_imm,
        input  id_dr, id_we, id_is_load
    );
endinterface

// File: rtl/decode_stage.sv
// LC-3b instruction decode stage: field decode, operand forwarding from
// EX/MEM/WB, load-use stall, and the ID/EX register with flush and back-pressure.
module decode_stage (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDW  = 4'h6,
        OP_STW  = 4'h7,
        OP_RTI  = 4'h8,
        OP_XOR  = 4'h9,
        OP_RSVA = 4'hA,
        OP_RSVB = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    opcode_e     opcode;
    logic [15:0] instr;

    logic        use_sr1;
    logic        use_sr2;
    logic        is_store;
    logic        dec_we;
    logic [2:0]  dec_dr;
    logic        dec_is_load;
    logic [15:0] dec_imm;

    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [15:0] sr1_val;
    logic [15:0] sr2_val;
    logic [15:0] op1;
    logic [15:0] op2;

    logic        hazard;
    logic        hold;
    logic        accept;

    logic        id_valid_q;
    logic [15:0] id_instr_q;
    logic [15:0] id_pc_q;
    logic [15:0] id_op1_q;
    logic [15:0] id_op2_q;
    logic [15:0] id_imm_q;
    logic [2:0]  id_dr_q;
    logic        id_we_q;
    logic        id_is_load_q;

    assign instr  = bus.in_instr;
    assign opcode = opcode_e'(instr[15:12]);

    // Per-opcode source usage, destination and immediate format.
    always_comb begin
        use_sr1     = 1'b0;
        use_sr2     = 1'b0;
        is_store    = 1'b0;
        dec_we      = 1'b0;
        dec_dr      = instr[11:9];
        dec_is_load = 1'b0;
        dec_imm     = 16'h0000;
        case (opcode)
            OP_ADD, OP_AND, OP_XOR: begin
                use_sr1 = 1'b1;
                use_sr2 = !instr[5];
                dec_we  = 1'b1;
                dec_imm = {{11{instr[4]}}, instr[4:0]};
            end
            OP_SHF: begin
                use_sr1 = 1'b1;
                dec_we  = 1'b1;
                dec_imm = {10'b0, instr[5:0]};
            end
            OP_LDB, OP_LDW: begin
                use_sr1     = 1'b1;
                dec_we      = 1'b1;
                dec_is_load = 1'b1;
                dec_imm     = {{10{instr[5]}}, instr[5:0]};
            end
            OP_STB, OP_STW: begin
                use_sr1  = 1'b1;
                use_sr2  = 1'b1;
                is_store = 1'b1;
                dec_imm  = {{10{instr[5]}}, instr[5:0]};
            end
            OP_JMP: begin
                use_sr1 = 1'b1;
            end
            OP_JSR: begin
                dec_we = 1'b1;
                dec_dr = 3'd7;
                if (instr[11]) begin
                    dec_imm = {{5{instr[10]}}, instr[10:0]};
                end else begin
                    use_sr1 = 1'b1;
                end
            end
            OP_BR: begin
                dec_imm = {{7{instr[8]}}, instr[8:0]};
            end
            OP_LEA: begin
                dec_we  = 1'b1;
                dec_imm = {{7{instr[8]}}, instr[8:0]};
            end
            OP_TRAP: begin
                dec_imm = {8'b0, instr[7:0]};
            end
            default: begin
            end
        endcase
    end

    // Stores read the value to be written through the DR field.
    assign sr1_addr = instr[8:6];
    assign sr2_addr = is_store ? instr[11:9] : instr[2:0];

    // The register file writes on the edge, so a WB match must bypass the read.
    always_comb begin
        sr1_val = bus.sr1_data;
        if (id_valid_q && bus.ex_fwd_we && bus.ex_fwd_dr == sr1_addr) begin
            sr1_val = bus.ex_fwd_data;
        end else if (bus.mem_fwd_we && bus.mem_fwd_dr == sr1_addr) begin
            sr1_val = bus.mem_fwd_data;
        end else if (bus.wb_we && bus.wb_dr == sr1_addr) begin
            sr1_val = bus.wb_data;
        end
    end

    always_comb begin
        sr2_val = bus.sr2_data;
        if (id_valid_q && bus.ex_fwd_we && bus.ex_fwd_dr == sr2_addr) begin
            sr2_val = bus.ex_fwd_data;
        end else if (bus.mem_fwd_we && bus.mem_fwd_dr == sr2_addr) begin
            sr2_val = bus.mem_fwd_data;
        end else if (bus.wb_we && bus.wb_dr == sr2_addr) begin
            sr2_val = bus.wb_data;
        end
    end

    assign op1 = use_sr1 ? sr1_val : 16'h0000;
    assign op2 = use_sr2 ? sr2_val : 16'h0000;

    // A load in EX has no data yet; one bubble lets it reach MEM for forwarding.
    assign hazard = bus.in_valid && id_valid_q && id_is_load_q && id_we_q &&
                    ((use_sr1 && id_dr_q == sr1_addr) ||
                     (use_sr2 && id_dr_q == sr2_addr));

    assign hold     = id_valid_q && !bus.ex_ready;
    assign accept   = bus.in_valid && !hazard;
    assign bus.in_ready = !bus.flush && !hazard && (bus.ex_ready || !id_valid_q);

    // ID/EX register: flush beats hold, hold beats bubble/capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= 16'h0000;
            id_pc_q      <= 16'h0000;
            id_op1_q     <= 16'h0000;
            id_op2_q     <= 16'h0000;
            id_imm_q     <= 16'h0000;
            id_dr_q      <= 3'd0;
            id_we_q      <= 1'b0;
            id_is_load_q <= 1'b0;
        end else if (bus.flush) begin
            id_valid_q <= 1'b0;
        end else if (!hold) begin
            id_valid_q <= accept;
            if (accept) begin
                id_instr_q   <= instr;
                id_pc_q      <= bus.in_pc;
                id_op1_q     <= op1;
                id_op2_q     <= op2;
                id_imm_q     <= dec_imm;
                id_dr_q      <= dec_dr;
                id_we_q      <= dec_we;
                id_is_load_q <= dec_is_load;
            end
        end
    end

    assign bus.sr1        = sr1_addr;
    assign bus.sr2        = sr2_addr;
    assign bus.id_valid   = id_valid_q;
    assign bus.id_instr   = id_instr_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_op1     = id_op1_q;
    assign bus.id_op2     = id_op2_q;
    assign bus.id_imm     = id_imm_q;
    assign bus.id_dr      = id_dr_q;
    assign bus.id_we      = id_we_q;
    assign bus.id_is_load = id_is_load_q;

endmodule
